// File: rtl/windowed_register_file.sv
// windowed_register_file: SPARC windowed regfile (RA/RB/RD->PA/PB/PD comb reads, PW/RW/LE write, Save/Restore/CwpLE/WimLE window control -> CWP/WIM/Ovf/Unf)
module windowed_register_file #(
  parameter int WIDTH = 32,
  parameter int NWINDOWS = 8,
  parameter int CWPW = $clog2(NWINDOWS),
  parameter bit BYPASS = 1
) (
  input  logic                Clk,
  input  logic                Clr_n,
  output logic [WIDTH-1:0]    PA,
  output logic [WIDTH-1:0]    PB,
  output logic [WIDTH-1:0]    PD,
  input  logic [4:0]          RA,
  input  logic [4:0]          RB,
  input  logic [4:0]          RD,
  input  logic [WIDTH-1:0]    PW,
  input  logic [4:0]          RW,
  input  logic                LE,
  input  logic                Save,
  input  logic                Restore,
  input  logic                WimLE,
  input  logic [NWINDOWS-1:0] WimIn,
  input  logic                CwpLE,
  input  logic [CWPW-1:0]     CwpIn,
  output logic [CWPW-1:0]     CWP,
  output logic [NWINDOWS-1:0] WIM,
  output logic                Ovf,
  output logic                Unf
);
  localparam int NPHYS = 8 + 16 * NWINDOWS;
  localparam int PIW = $clog2(NPHYS);
  function automatic logic [PIW-1:0] phys(input logic [4:0] r, input logic [CWPW-1:0] c);
    int ri, ci, ni;
    ri = int'(r);
    ci = int'(c);
    ni = (ci == NWINDOWS - 1) ? 0 : ci + 1;
    return PIW'(ri < 8 ? ri : ri < 24 ? 8 + 16 * ci + ri - 8 : 8 + 16 * ni + ri - 24);
  endfunction
  logic [WIDTH-1:0] regs [NPHYS];
  logic             wr_en;
  logic [PIW-1:0]   w_idx, a_idx, b_idx, d_idx;
  logic [CWPW-1:0]  cm1, cp1, cwp_ld;
  assign wr_en  = LE && RW != 5'd0;
  assign w_idx  = phys(RW, CWP);
  assign a_idx  = phys(RA, CWP);
  assign b_idx  = phys(RB, CWP);
  assign d_idx  = phys(RD, CWP);
  assign PA     = (BYPASS && wr_en && a_idx == w_idx) ? PW : regs[a_idx];
  assign PB     = (BYPASS && wr_en && b_idx == w_idx) ? PW : regs[b_idx];
  assign PD     = (BYPASS && wr_en && d_idx == w_idx) ? PW : regs[d_idx];
  assign cm1    = (CWP == '0) ? CWPW'(NWINDOWS - 1) : CWP - 1'b1;
  assign cp1    = (CWP == CWPW'(NWINDOWS - 1)) ? '0 : CWP + 1'b1;
  assign cwp_ld = CWPW'(int'(CwpIn) % NWINDOWS);
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[w_idx] <= PW;
    end
  end
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      CWP <= '0;
      WIM <= '0;
      Ovf <= 1'b0;
      Unf <= 1'b0;
    end else begin
      Ovf <= 1'b0;
      Unf <= 1'b0;
      if (CwpLE) CWP <= cwp_ld;
      else if (Save && !Restore) begin
        if (WIM[cm1]) Ovf <= 1'b1;
        else CWP <= cm1;
      end else if (Restore && !Save) begin
        if (WIM[cp1]) Unf <= 1'b1;
        else CWP <= cp1;
      end
      if (WimLE) WIM <= WimIn;
    end
  end
endmodule

// File: tb/tb_windowed_register_file.sv
// tb_windowed_register_file: directed self-checking bench for windowed_register_file (N=8, BYPASS=1)
module tb_windowed_register_file;
  logic        Clk = 1'b0, Clr_n = 1'b0;
  logic [31:0] PA, PB, PD, PW = '0;
  logic [4:0]  RA = '0, RB = '0, RD = '0, RW = '0;
  logic        LE = 1'b0, Save = 1'b0, Restore = 1'b0, WimLE = 1'b0, CwpLE = 1'b0;
  logic [7:0]  WimIn = '0, WIM;
  logic [2:0]  CwpIn = '0, CWP;
  logic        Ovf, Unf;
  int          passed = 0, total = 0;
  windowed_register_file dut (
    .Clk(Clk), .Clr_n(Clr_n), .PA(PA), .PB(PB), .PD(PD), .RA(RA), .RB(RB), .RD(RD),
    .PW(PW), .RW(RW), .LE(LE), .Save(Save), .Restore(Restore), .WimLE(WimLE),
    .WimIn(WimIn), .CwpLE(CwpLE), .CwpIn(CwpIn), .CWP(CWP), .WIM(WIM), .Ovf(Ovf), .Unf(Unf)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  function automatic logic [31:0] flat(input int x);
    return x == 0 ? 32'd0 : 32'(20 + x);
  endfunction
  initial begin
    repeat (2) @(posedge Clk);
    #1 Clr_n = 1'b1;
    RA = 5'd5;
    #1;
    check("rst_cwp", 32'(CWP), 0);
    check("rst_wim", 32'(WIM), 0);
    check("rst_read", PA, 0);
    for (int i = 1; i < 32; i++) begin
      RW = 5'(i); PW = 32'(20 + i); LE = 1'b1; RA = 5'(i);
      #1;
      check($sformatf("bypass_r%0d", i), PA, 32'(20 + i));
      tick();
    end
    LE = 1'b0;
    for (int i = 1; i < 32; i++) begin
      RA = 5'(i); RB = 5'(i - 1); RD = 5'(i < 2 ? 0 : i - 2);
      #1;
      check($sformatf("flat_a%0d", i), PA, flat(i));
      check($sformatf("flat_b%0d", i), PB, flat(i - 1));
      check($sformatf("flat_d%0d", i), PD, flat(i < 2 ? 0 : i - 2));
    end
    RW = 5'd0; PW = 32'd20; LE = 1'b1; RA = 5'd0;
    #1 check("r0_bypass", PA, 0);
    tick();
    LE = 1'b0;
    #1 check("r0_after", PA, 0);
    RA = 5'd1;
    #1 Clr_n = 1'b0;
    #1 check("midrst_async", PA, 0);
    tick();
    Clr_n = 1'b1;
    RB = 5'd24;
    #1;
    check("midrst_cwp", 32'(CWP), 0);
    check("midrst_wim", 32'(WIM), 0);
    check("midrst_r24", PB, 0);
    RW = 5'd8; PW = 32'hA5; LE = 1'b1;
    tick();
    RW = 5'd1; PW = 32'h11;
    tick();
    LE = 1'b0; Save = 1'b1;
    tick();
    Save = 1'b0; RA = 5'd24; RB = 5'd8; RD = 5'd1;
    #1;
    check("ovl_cwp", 32'(CWP), 7);
    check("ovl_r24", PA, 32'hA5);
    check("ovl_r8", PB, 0);
    check("ovl_glob", PD, 32'h11);
    CwpLE = 1'b1; CwpIn = 3'd7;
    tick();
    CwpLE = 1'b0; Restore = 1'b1;
    tick();
    Restore = 1'b0;
    check("wrap_cwp", 32'(CWP), 0);
    RW = 5'd24; PW = 32'h5A; LE = 1'b1;
    tick();
    LE = 1'b0; CwpLE = 1'b1; CwpIn = 3'd1;
    tick();
    CwpLE = 1'b0; RA = 5'd8;
    #1 check("wrap_ins_w1", PA, 32'h5A);
    CwpLE = 1'b1; CwpIn = 3'd0; WimLE = 1'b1; WimIn = 8'h80;
    tick();
    CwpLE = 1'b0; WimLE = 1'b0;
    check("ovf_wim", 32'(WIM), 32'h80);
    check("ovf_pre", 32'(Ovf), 0);
    Save = 1'b1;
    tick();
    Save = 1'b0;
    check("ovf_pulse", 32'(Ovf), 1);
    check("ovf_cwp", 32'(CWP), 0);
    tick();
    check("ovf_clear", 32'(Ovf), 0);
    WimLE = 1'b1; WimIn = 8'h02;
    tick();
    WimLE = 1'b0; Restore = 1'b1;
    tick();
    Restore = 1'b0;
    check("unf_pulse", 32'(Unf), 1);
    check("unf_cwp", 32'(CWP), 0);
    tick();
    check("unf_clear", 32'(Unf), 0);
    WimLE = 1'b1; WimIn = 8'h82;
    tick();
    WimLE = 1'b0; Save = 1'b1; Restore = 1'b1;
    tick();
    Save = 1'b0; Restore = 1'b0;
    check("sr_cwp", 32'(CWP), 0);
    check("sr_ovf", 32'(Ovf), 0);
    check("sr_unf", 32'(Unf), 0);
    CwpLE = 1'b1; CwpIn = 3'd3; Save = 1'b1;
    WimLE = 1'b1; WimIn = 8'h04;
    tick();
    WimLE = 1'b0;
    CwpLE = 1'b0; Save = 1'b0;
    check("cwple_cwp", 32'(CWP), 3);
    check("cwple_ovf", 32'(Ovf), 0);
    CwpLE = 1'b1; CwpIn = 3'd0; WimLE = 1'b1; WimIn = 8'h00;
    tick();
    CwpLE = 1'b0; WimIn = 8'h80; Save = 1'b1;
    tick();
    WimLE = 1'b0; Save = 1'b0;
    check("wimsave_cwp", 32'(CWP), 7);
    check("wimsave_wim", 32'(WIM), 32'h80);
    check("wimsave_ovf", 32'(Ovf), 0);
    RW = 5'd16; PW = 32'h77; LE = 1'b1; Save = 1'b1;
    tick();
    LE = 1'b0; Save = 1'b0; RA = 5'd16;
    #1;
    check("wrsave_cwp", 32'(CWP), 6);
    check("wrsave_new", PA, 0);
    CwpLE = 1'b1; CwpIn = 3'd7;
    tick();
    CwpLE = 1'b0;
    check("wrsave_old", PA, 32'h77);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/windowed_register_file.md
# windowed_register_file

- Parametrised SPARC windowed integer register file; successor to the flat 32×32 `register_file`.
- Provides the same three combinational read ports (PA/PB/PD) and one clocked write port (PW/RW/LE), addressed by 5-bit logical register numbers.
- Maps logical registers onto `NWINDOWS` overlapping windows plus 8 globals, selected by a current window pointer (CWP).
- Maintains CWP, WIM and window overflow/underflow trap detection for SAVE/RESTORE. Sits between decode (operand fetch) and writeback in the integer pipeline.

## Interface
Parameters:
- `WIDTH`, 32, data width of every register and port.
- `NWINDOWS`, 8, number of register windows (2..32); physical storage is 8 + 16·NWINDOWS registers.
- `CWPW`, $clog2(NWINDOWS), CWP width.
- `BYPASS`, 1, 1 = write-to-read forwarding in the same cycle; 0 = none.

Ports:
- `Clk`  in  1  clock; all state updates on rising edge.
- `Clr_n`  in  1  reset, asynchronous, active-low.
- `PA`, `PB`, `PD`  out  WIDTH  read data for RA, RB, RD.
- `RA`, `RB`, `RD`  in  5  logical read addresses.
- `PW`  in  WIDTH  write data.
- `RW`  in  5  logical write address.
- `LE`  in  1  write enable.
- `Save`  in  1  SAVE request: move to window CWP−1.
- `Restore`  in  1  RESTORE request: move to window CWP+1.
- `WimLE`  in  1  load WIM from WimIn.
- `WimIn`  in  NWINDOWS  new WIM value.
- `CwpLE`  in  1  load CWP from CwpIn (trap entry/return).
- `CwpIn`  in  CWPW  new CWP.
- `CWP`  out  CWPW  current window pointer.
- `WIM`  out  NWINDOWS  window invalid mask.
- `Ovf`  out  1  window overflow trap pulse.
- `Unf`  out  1  window underflow trap pulse.

## Operation
Logical-to-physical mapping (P = physical index, c = CWP, N = NWINDOWS):
- r0: reads 0; writes discarded.
- r1–r7 (globals): P = r.
- r8–r15 (outs): P = 8 + 16c + (r−8).
- r16–r23 (locals): P = 8 + 16c + 8 + (r−16).
- r24–r31 (ins): P = 8 + 16·((c+1) mod N) + (r−24). The ins of window c are therefore the outs of window c+1.

Reads and writes:
- Reads are combinational from the current CWP.
- With BYPASS=1, if LE=1, RW≠0 and the read address maps to the same P as RW, the read port returns PW.
- A write (LE=1, RW≠0) stores PW at P computed from the pre-edge CWP.

Window control, sampled each rising edge, highest priority first:
1. `CwpLE`: CWP ← CwpIn mod N. Save/Restore ignored, no trap.
2. `Save` and `Restore` both 1: no effect, no trap.
3. `Save`: n = (c−1) mod N. If pre-edge WIM[n]=1: Ovf=1 for one cycle, CWP unchanged. Otherwise CWP ← n.
4. `Restore`: n = (c+1) mod N. If pre-edge WIM[n]=1: Unf=1 for one cycle, CWP unchanged. Otherwise CWP ← n.

Other rules:
- WimLE updates WIM on the same edge; window checks always use the pre-edge WIM.
- Ovf/Unf are registered and low in every cycle without a trapping request.
- Arithmetic on CWP wraps modulo N (0−1 → N−1; N−1+1 → 0).

## Timing
- Reset (Clr_n=0, any time, including mid-operation): all physical registers 0, CWP=0, WIM=0, Ovf=0, Unf=0. Outputs reflect this immediately.
- Read latency 0 cycles, combinational from RA/RB/RD, CWP and storage.
- Write visible on read ports:
  - the cycle after the edge;
  - the same cycle when BYPASS=1.
- CWP, WIM, Ovf, Unf change only on a rising edge (or reset). A SAVE on edge k makes reads after edge k use the new window.
- A write combined with Save/Restore on the same edge targets the old window.
- Back-to-back Save on consecutive edges is allowed; each is checked independently.

## Test plan
- Reset and r0:
  - Stimulus: assert Clr_n=0 mid-run, release; write PW=20 to RW=0.
  - Required: CWP=0, WIM=0, all reads 0; r0 still reads 0.
- Flat behaviour:
  - Stimulus: LE=1, write PW=20+i to RW=i for i=1..31; read RA=i, RB=i−1, RD=i−2.
  - Required: each read returns the written value; with BYPASS=1 the same-cycle RA=RW read returns PW.
- Window overlap:
  - Stimulus: at CWP=0 write 0xA5 to r8; Save.
  - Required: CWP=7 (N=8); r24 reads 0xA5; r8 reads 0; globals unchanged.
- Wrap-around:
  - Stimulus: CwpLE with CwpIn=7, then Restore.
  - Required: CWP=0; ins map to window 1.
- Overflow:
  - Stimulus: WIM=0x80, CWP=0, Save.
  - Required: Ovf=1 for exactly one cycle, CWP stays 0.
  - Stimulus: WIM=0x02, CWP=0, Restore.
  - Required: Unf=1, CWP stays 0.
- Simultaneous events:
  - Stimulus: Save+Restore on one edge.
  - Required: no change.
  - Stimulus: CwpLE+Save.
  - Required: CWP=CwpIn, no Ovf.
  - Stimulus: WimLE (set bit 7) + Save at CWP=0 on one edge.
  - Required: Save succeeds (old WIM used), CWP=7.
